// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage feeding the instruction register.
//   Holds the PC, runs a read handshake with instruction memory, captures the
//   returned word into ir_word, pulses ir_load for one cycle, then advances pc.
//   The control FSM may redirect pc via pc_load while the unit is idle.
// Optional feature: define FETCH_TIMEOUT_EN to abort a read after TIMEOUT
//   RD cycles without mem_ready. An abort sets the sticky fetch_err flag.
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   fetch_req              start one fetch (accepted only in IDLE)
//   pc_load, pc_target     PC redirect (accepted only in IDLE, wins over fetch_req)
//   mem_addr, mem_rd       memory read address (= pc) and read request
//   mem_rdata, mem_ready   memory read data and data-valid
//   ir_word, ir_load       captured instruction and one-cycle IR load strobe
//   busy                   high in any state other than IDLE
//   pc                     current program counter
//   fetch_err              sticky timeout flag (tied 0 without FETCH_TIMEOUT_EN)
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] ir_word,
  output logic              ir_load,
  output logic              busy,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  // A zero timeout would abort every fetch before memory could answer.
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("instr_fetch_unit: TIMEOUT must be at least 1");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // Outputs decoded from the registered state.
  assign mem_rd   = (state_q == S_RD);
  assign ir_load  = (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);
  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign ir_word  = ir_q;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pc_load) begin
          pc_d = pc_target;
        end else if (fetch_req) begin
          state_d = S_RD;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_RD: begin
        // A capture in the same cycle as the final count still completes normally.
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_LOAD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_LOAD: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: transaction-level reference model
// (pc, last captured word, error flag) checked against randomized fetches,
// PC redirects, resets mid-fetch and busy-time noise.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned RESET_PC = 0;
  localparam int unsigned TIMEOUT  = 15;
  localparam int          PC_MOD   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_req;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [DATA_W-1:0] ir_word;
  logic              ir_load;
  logic              busy;
  logic [ADDR_W-1:0] pc;
  logic              fetch_err;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(RESET_PC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .fetch_req(fetch_req),
    .pc_load  (pc_load),
    .pc_target(pc_target),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .ir_word  (ir_word),
    .ir_load  (ir_load),
    .busy     (busy),
    .pc       (pc),
    .fetch_err(fetch_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int              m_pc;
  logic [DATA_W-1:0] m_ir;
  logic            m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    reset     = 1'b0;
    fetch_req = 1'b0;
    pc_load   = 1'b0;
    pc_target = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},    32'(busy),    32'(0));
    check({tag, ".mem_rd"},  32'(mem_rd),  32'(0));
    check({tag, ".ir_load"}, 32'(ir_load), 32'(0));
    check({tag, ".pc"},      32'(pc),      32'(m_pc));
    check({tag, ".ir_word"}, 32'(ir_word), 32'(m_ir));
    check({tag, ".err"},     32'(fetch_err), 32'(m_err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset     = 1'b1;
    fetch_req = 1'($urandom_range(0, 1));
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    clear_inputs();
    m_pc  = RESET_PC;
    m_ir  = '0;
    m_err = 1'b0;
    check_idle("reset");
  endtask

  task automatic do_pc_load(input int target, input logic with_req);
    @(negedge clk);
    pc_load   = 1'b1;
    pc_target = ADDR_W'(target);
    fetch_req = with_req;
    @(negedge clk);
    clear_inputs();
    m_pc = target % PC_MOD;
    check_idle("pcload");
    @(negedge clk);
    check("pcload.stay_idle", 32'(busy), 32'(0));
  endtask

  // One fetch answered after `waits` stall cycles; noise drives ignored requests while busy.
  task automatic do_fetch(input int waits, input logic [DATA_W-1:0] data, input logic noise);
    @(negedge clk);
    fetch_req = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = DATA_W'($urandom);
    @(negedge clk);
    m_err = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      check("rd.mem_rd",   32'(mem_rd),   32'(1));
      check("rd.busy",     32'(busy),     32'(1));
      check("rd.ir_load",  32'(ir_load),  32'(0));
      check("rd.mem_addr", 32'(mem_addr), 32'(m_pc));
      check("rd.pc",       32'(pc),       32'(m_pc));
      check("rd.ir_hold",  32'(ir_word),  32'(m_ir));
      check("rd.err",      32'(fetch_err), 32'(0));
      mem_ready = (i == waits);
      mem_rdata = (i == waits) ? data : DATA_W'($urandom);
      fetch_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      pc_load   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      pc_target = ADDR_W'($urandom);
      @(negedge clk);
    end
    check("load.ir_load", 32'(ir_load), 32'(1));
    check("load.busy",    32'(busy),    32'(1));
    check("load.mem_rd",  32'(mem_rd),  32'(0));
    check("load.ir_word", 32'(ir_word), 32'(data));
    check("load.pc",      32'(pc),      32'(m_pc));
    m_ir      = data;
    mem_ready = 1'($urandom_range(0, 1));
    fetch_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    pc_load   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    pc_target = ADDR_W'($urandom);
    @(negedge clk);
    clear_inputs();
    m_pc = (m_pc + 1) % PC_MOD;
    check_idle("after_fetch");
  endtask

  task automatic do_reset_mid(input int cycles);
    @(negedge clk);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      check("rstmid.mem_rd", 32'(mem_rd), 32'(1));
      @(negedge clk);
    end
    reset     = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = DATA_W'($urandom);
    @(negedge clk);
    clear_inputs();
    m_pc  = RESET_PC;
    m_ir  = '0;
    m_err = 1'b0;
    check_idle("rstmid");
    @(negedge clk);
    check("rstmid.no_load", 32'(ir_load), 32'(0));
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic do_timeout();
    @(negedge clk);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    m_err = 1'b0;
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      check("to.mem_rd", 32'(mem_rd), 32'(1));
      check("to.err",    32'(fetch_err), 32'(0));
      @(negedge clk);
    end
    m_err = 1'b1;
    check_idle("timeout");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    clear_inputs();
    m_pc  = 0;
    m_ir  = '0;
    m_err = 1'b0;

    do_reset();
    do_fetch(0, 16'hA5C3, 1'b0);
    do_pc_load(9'h1FF, 1'b0);
    do_fetch(3, DATA_W'($urandom), 1'b0);
    do_pc_load(9'h0A5, 1'b1);
    do_fetch(2, DATA_W'($urandom), 1'b1);
    do_reset_mid(2);
`ifdef FETCH_TIMEOUT_EN
    do_timeout();
    do_fetch(int'(TIMEOUT) - 1, DATA_W'($urandom), 1'b0);
    do_fetch(0, DATA_W'($urandom), 1'b0);
`endif

    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 2)
        do_pc_load(int'($urandom_range(0, PC_MOD - 1)), 1'($urandom_range(0, 1)));
      else if (r <= 8)
        do_fetch(int'($urandom_range(0, 5)), DATA_W'($urandom), 1'($urandom_range(0, 1)));
      else
        do_reset_mid(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
